// File: rtl/adc_sample_averager.sv
// Per-channel decimating averager: sums 2^AVG_LOG2 samples per channel, emits the truncated mean one cycle
// after the completing sample through a single-entry valid/ready register; results arriving while it is stalled are dropped and flagged.
module adc_sample_averager #(
    parameter int NUM_CH   = 2,
    parameter int AVG_LOG2 = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        in_valid,
    input  logic [4:0]  in_channel,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_channel,
    output logic [11:0] out_data,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int ACC_W = 12 + AVG_LOG2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q [NUM_CH];
    logic [ACC_W-1:0]       acc_d [NUM_CH];
    logic [AVG_LOG2-1:0]    cnt_q [NUM_CH];
    logic [AVG_LOG2-1:0]    cnt_d [NUM_CH];
    logic [4:0]             out_channel_q, out_channel_d;
    logic [11:0]            out_data_q, out_data_d;
    logic                   overrun_q, overrun_d;

    logic [ACC_W-1:0]       sum;
    logic                   res_vld;
    logic [11:0]            res_dat;
    logic                   load_en;
    logic                   drop;

    // Channel ids outside 0..NUM_CH-1 never match any loop index, so they leave all state untouched.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum     = '0;
        res_vld = 1'b0;
        res_dat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid && (in_channel == 5'(i))) begin
                sum = acc_q[i] + ACC_W'(in_data);
                if (cnt_q[i] == '1) begin
                    res_vld  = 1'b1;
                    res_dat  = sum[ACC_W-1:AVG_LOG2];
                    acc_d[i] = '0;
                    cnt_d[i] = '0;
                end else begin
                    acc_d[i] = sum;
                    cnt_d[i] = cnt_q[i] + AVG_LOG2'(1);
                end
            end
        end
    end

    always_comb begin
        load_en       = res_vld && ((state_q == EMPTY) || out_ready);
        drop          = res_vld && (state_q == FULL) && !out_ready;
        out_channel_d = load_en ? in_channel : out_channel_q;
        out_data_d    = load_en ? res_dat : out_data_q;
        // A drop in the same cycle as a clear leaves the flag set.
        overrun_d     = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
        state_d       = state_q;
        case (state_q)
            EMPTY:   if (res_vld) state_d = FULL;
            FULL:    if (out_ready && !res_vld) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q       <= EMPTY;
            out_channel_q <= '0;
            out_data_q    <= '0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            overrun_q     <= overrun_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        out_valid   = (state_q == FULL);
        out_channel = out_channel_q;
        out_data    = out_data_q;
        overrun     = overrun_q;
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager (NUM_CH=2, AVG_LOG2=2): directed cases plus random traffic
// checked against a queue-based model of block means and the output register.
module tb_adc_sample_averager;

    localparam int NUM_CH   = 2;
    localparam int AVG_LOG2 = 2;
    localparam int BLK      = 1 << AVG_LOG2;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        in_valid;
    logic [4:0]  in_channel;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_channel;
    logic [11:0] out_data;
    logic        overrun;
    logic        overrun_clr;

    adc_sample_averager #(.NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (in_valid),
        .in_channel    (in_channel),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_channel   (out_channel),
        .out_data      (out_data),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: pending samples per channel and the expected output register contents.
    int unsigned blk_q [NUM_CH][$];
    bit          exp_vld;
    int unsigned exp_ch;
    int unsigned exp_dat;
    bit          exp_ovr;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) blk_q[c].delete();
        exp_vld = 0;
        exp_ch  = 0;
        exp_dat = 0;
        exp_ovr = 0;
    endtask

    task automatic rst();
        reset_reset_n = 1'b0;
        in_valid      = 1'b0;
        in_channel    = '0;
        in_data       = '0;
        out_ready     = 1'b0;
        overrun_clr   = 1'b0;
        @(posedge clk_clk); #1;
        model_clear();
        chk("rst_vld", out_valid, 0);
        chk("rst_ch", out_channel, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_ovr", overrun, 0);
        reset_reset_n = 1'b1;
    endtask

    // One clock: drive inputs, predict, advance past the edge, compare.
    task automatic cyc(input bit v, input int unsigned ch, input int unsigned d,
                       input bit rdy, input bit clr);
        bit          res;
        int unsigned rch, rdat, sum;
        in_valid    = v;
        in_channel  = 5'(ch);
        in_data     = 12'(d);
        out_ready   = rdy;
        overrun_clr = clr;
        res = 0; rch = 0; rdat = 0;
        if (v && ch < NUM_CH) begin
            blk_q[ch].push_back(d);
            if (blk_q[ch].size() == BLK) begin
                sum = 0;
                foreach (blk_q[ch][k]) sum += blk_q[ch][k];
                res  = 1;
                rch  = ch;
                rdat = sum / BLK;
                blk_q[ch].delete();
            end
        end
        @(posedge clk_clk); #1;
        if (res && exp_vld && !rdy) exp_ovr = 1;
        else if (clr) exp_ovr = 0;
        if (res && (!exp_vld || rdy)) begin
            exp_vld = 1; exp_ch = rch; exp_dat = rdat;
        end else if (exp_vld && rdy) begin
            exp_vld = 0;
        end
        chk("vld", out_valid, exp_vld);
        chk("ovr", overrun, exp_ovr);
        if (exp_vld) begin
            chk("ch", out_channel, exp_ch);
            chk("dat", out_data, exp_dat);
        end
    endtask

    initial begin
        @(posedge clk_clk); #1;
        rst();

        // Single channel block: 406 >> 2 = 101.
        for (int i = 0; i < 4; i++) cyc(1, 1, 100 + i, 1, 0);
        chk("t1_vld", out_valid, 1);
        chk("t1_ch", out_channel, 1);
        chk("t1_dat", out_data, 101);
        cyc(0, 0, 0, 1, 0);
        chk("t1_drain", out_valid, 0);

        // Interleaved full-scale and small channels.
        rst();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 4095, 1, 0);
            if (i == 3) begin
                chk("t2_ch0", out_channel, 0);
                chk("t2_d0", out_data, 4095);
            end
            cyc(1, 1, i, 1, 0);
        end
        chk("t2_ch1", out_channel, 1);
        chk("t2_d1", out_data, 1);

        // Out-of-range channel samples mixed into a block.
        rst();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5, 4095, 1, 0);
            cyc(1, 0, 7 + 2 * i, 1, 0);
        end
        chk("t3_dat", out_data, 10);
        cyc(1, 5, 4095, 1, 0);
        chk("t3_noextra", out_valid, 0);

        // Drop under back-pressure, then drain.
        rst();
        for (int i = 0; i < 4; i++) cyc(1, 0, 10, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 20, 0, 0);
        chk("t4_ch", out_channel, 0);
        chk("t4_dat", out_data, 10);
        chk("t4_ovr", overrun, 1);
        cyc(0, 0, 0, 1, 0);
        chk("t4_drain", out_valid, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t4_clr", overrun, 0);

        // Replacement in the accepting cycle is not a drop.
        rst();
        for (int i = 0; i < 4; i++) cyc(1, 0, 10, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 20, 0, 0);
        cyc(1, 1, 20, 1, 0);
        chk("t5_vld", out_valid, 1);
        chk("t5_ch", out_channel, 1);
        chk("t5_dat", out_data, 20);
        chk("t5_ovr", overrun, 0);

        // Reset mid-block discards the partial sum.
        rst();
        for (int i = 0; i < 3; i++) cyc(1, 0, 1000, 1, 0);
        rst();
        rst();
        for (int i = 0; i < 4; i++) cyc(1, 0, 8, 1, 0);
        chk("t6_dat", out_data, 8);
        chk("t6_vld", out_valid, 1);

        // Random traffic, including idle cycles, bad channels, stalls and clears.
        rst();
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 4095),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
